// File: rtl/hazard_ctrl_pkg.sv
// Shared codes for the pipeline hazard controller: operand-use sentinel,
// forwarding-mux select encodings and the result-latency classes.
package hazard_ctrl_pkg;

    // Tuse value meaning "this operand is not read by the instruction"
    localparam logic [1:0] TUSE_NONE   = 2'b11;

    // D-stage forwarding selects (fwd_rs_D / fwd_rt_D)
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_E       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] FWD_W       = 2'b11;

    // E-stage forwarding selects (fwd_rs_E / fwd_rt_E)
    localparam logic [1:0] FWD_EX_IDEX = 2'b00;
    localparam logic [1:0] FWD_EX_M    = 2'b01;
    localparam logic [1:0] FWD_EX_W    = 2'b10;

    // Result latency, counted from E entry
    localparam logic [1:0] TNEW_PC8    = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    // Scoreboard stage indices
    localparam int unsigned STG_E = 0;
    localparam int unsigned STG_M = 1;
    localparam int unsigned STG_W = 2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: D-stage operand/destination info in,
// stall and forwarding-mux selects out.
interface hazard_ctrl_if #(
    parameter int RAW = 5,
    parameter int TW  = 2
);
    logic [RAW-1:0] d_rs;
    logic [RAW-1:0] d_rt;
    logic [TW-1:0]  d_tuse_rs;
    logic [TW-1:0]  d_tuse_rt;
    logic [RAW-1:0] d_dst;
    logic [TW-1:0]  d_tnew;
    logic           d_we;

    logic           stall;
    logic           flush_E;
    logic [1:0]     fwd_rs_D;
    logic [1:0]     fwd_rt_D;
    logic [1:0]     fwd_rs_E;
    logic [1:0]     fwd_rt_E;
    logic           fwd_rt_M;

    // Decode side: presents D-stage info, consumes pipeline controls
    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_we,
        input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

    // Hazard controller side
    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_we,
        output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
endinterface

// File: rtl/hazard_ctrl_match.sv
// One source-register vs. one in-flight producer comparison.
// hit:   the producer writes this register (register 0 never matches).
// ready: hit and the producer's result already exists (tnew == 0).
module hazard_ctrl_match #(
    parameter int RAW = 5,
    parameter int TW  = 2
) (
    input  logic [RAW-1:0] src,
    input  logic [RAW-1:0] dst,
    input  logic           we,
    input  logic [TW-1:0]  tnew,
    output logic           hit,
    output logic           ready
);

    // Producer match and result availability
    always_comb begin
        hit   = we && (dst == src) && (src != '0);
        ready = hit && (tnew == '0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core. Keeps a scoreboard entry
// for the instructions in E, M and W, ages their Tnew each cycle, and from
// that plus the D-stage decode produces stall/flush and every forwarding select.
module hazard_ctrl #(
    parameter int RAW = 5,
    parameter int TW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        logic [RAW-1:0] dst;
        logic [TW-1:0]  tnew;
        logic           we;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
    } entry_t;

    entry_t e_q, m_q, w_q;
    entry_t d_info;
    logic   stall;

    // Per-stage producer view used by the D-stage comparators
    logic [RAW-1:0] stg_dst  [3];
    logic [TW-1:0]  stg_tnew [3];
    logic           stg_we   [3];

    // D-stage operands against E/M/W (bit index = STG_*)
    logic [2:0] rs_hit, rs_rdy, rt_hit, rt_rdy;
    // E-stage operands against M/W (bit 0 = M, bit 1 = W)
    logic [1:0] ers_hit, ers_rdy, ert_hit, ert_rdy;
    // M-stage store data against W
    logic       mrt_hit, mrt_rdy;

    // W keeps its operand fields only for scoreboard completeness
    logic unused_w_ops;
    assign unused_w_ops = ^{w_q.rs, w_q.rt};

    // Move one stage down the pipe: result is one cycle closer, never below 0
    function automatic entry_t age(input entry_t x);
        entry_t y;
        y = x;
        if (x.tnew != '0) begin
            y.tnew = x.tnew - TW'(1);
        end
        return y;
    endfunction

    // Stall verdict for one D operand; the youngest matching producer decides,
    // older producers of the same register are shadowed by it. W never stalls.
    function automatic logic op_stall(input logic [2:0]    hit,
                                      input logic [TW-1:0] tnew_e,
                                      input logic [TW-1:0] tnew_m,
                                      input logic [TW-1:0] tuse);
        logic r;
        r = 1'b0;
        if (tuse != TUSE_NONE) begin
            if (hit[STG_E]) begin
                r = (tnew_e > tuse);
            end else if (hit[STG_M]) begin
                r = (tnew_m > tuse);
            end
        end
        return r;
    endfunction

    // D-stage select: youngest matching producer, forwarded only once ready
    function automatic logic [1:0] fwd_d_sel(input logic [2:0] hit,
                                             input logic [2:0] rdy);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit[STG_E]) begin
            sel = rdy[STG_E] ? FWD_E : FWD_RF;
        end else if (hit[STG_M]) begin
            sel = rdy[STG_M] ? FWD_M : FWD_RF;
        end else if (hit[STG_W]) begin
            sel = rdy[STG_W] ? FWD_W : FWD_RF;
        end
        return sel;
    endfunction

    // E-stage select: M shadows W when both write the register
    function automatic logic [1:0] fwd_e_sel(input logic [1:0] hit,
                                             input logic [1:0] rdy);
        logic [1:0] sel;
        sel = FWD_EX_IDEX;
        if (hit[0]) begin
            sel = rdy[0] ? FWD_EX_M : FWD_EX_IDEX;
        end else if (hit[1]) begin
            sel = rdy[1] ? FWD_EX_W : FWD_EX_IDEX;
        end
        return sel;
    endfunction

    // Gather the D-stage instruction into scoreboard form
    always_comb begin
        d_info      = '0;
        d_info.dst  = hz.d_dst;
        d_info.tnew = hz.d_tnew;
        d_info.we   = hz.d_we;
        d_info.rs   = hz.d_rs;
        d_info.rt   = hz.d_rt;
    end

    // Flatten the scoreboard into per-stage producer arrays
    always_comb begin
        stg_dst[STG_E]  = e_q.dst;
        stg_tnew[STG_E] = e_q.tnew;
        stg_we[STG_E]   = e_q.we;
        stg_dst[STG_M]  = m_q.dst;
        stg_tnew[STG_M] = m_q.tnew;
        stg_we[STG_M]   = m_q.we;
        stg_dst[STG_W]  = w_q.dst;
        stg_tnew[STG_W] = w_q.tnew;
        stg_we[STG_W]   = w_q.we;
    end

    for (genvar s = 0; s < 3; s++) begin : g_dcmp
        hazard_ctrl_match #(.RAW(RAW), .TW(TW)) u_rs (
            .src   (hz.d_rs),
            .dst   (stg_dst[s]),
            .we    (stg_we[s]),
            .tnew  (stg_tnew[s]),
            .hit   (rs_hit[s]),
            .ready (rs_rdy[s])
        );
        hazard_ctrl_match #(.RAW(RAW), .TW(TW)) u_rt (
            .src   (hz.d_rt),
            .dst   (stg_dst[s]),
            .we    (stg_we[s]),
            .tnew  (stg_tnew[s]),
            .hit   (rt_hit[s]),
            .ready (rt_rdy[s])
        );
    end

    for (genvar s = 0; s < 2; s++) begin : g_ecmp
        hazard_ctrl_match #(.RAW(RAW), .TW(TW)) u_rs (
            .src   (e_q.rs),
            .dst   (stg_dst[s+1]),
            .we    (stg_we[s+1]),
            .tnew  (stg_tnew[s+1]),
            .hit   (ers_hit[s]),
            .ready (ers_rdy[s])
        );
        hazard_ctrl_match #(.RAW(RAW), .TW(TW)) u_rt (
            .src   (e_q.rt),
            .dst   (stg_dst[s+1]),
            .we    (stg_we[s+1]),
            .tnew  (stg_tnew[s+1]),
            .hit   (ert_hit[s]),
            .ready (ert_rdy[s])
        );
    end

    hazard_ctrl_match #(.RAW(RAW), .TW(TW)) u_mrt (
        .src   (m_q.rt),
        .dst   (w_q.dst),
        .we    (w_q.we),
        .tnew  (w_q.tnew),
        .hit   (mrt_hit),
        .ready (mrt_rdy)
    );

    // Scoreboard advance; a stalled D instruction leaves a bubble in E
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= age(m_q);
            m_q <= age(e_q);
            e_q <= stall ? '0 : d_info;
        end
    end

    // Stall OR-tree and forwarding priority encoders
    always_comb begin
        stall       = op_stall(rs_hit, e_q.tnew, m_q.tnew, hz.d_tuse_rs)
                    | op_stall(rt_hit, e_q.tnew, m_q.tnew, hz.d_tuse_rt);
        hz.stall    = stall;
        hz.flush_E  = stall;
        hz.fwd_rs_D = fwd_d_sel(rs_hit, rs_rdy);
        hz.fwd_rt_D = fwd_d_sel(rt_hit, rt_rdy);
        hz.fwd_rs_E = fwd_e_sel(ers_hit, ers_rdy);
        hz.fwd_rt_E = fwd_e_sel(ert_hit, ert_rdy);
        hz.fwd_rt_M = mrt_hit & mrt_rdy;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios with literal expectations,
// then randomized decode streams compared every cycle against an
// instruction-level model of the E/M/W pipe.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RAW(5), .TW(2)) hz ();

    hazard_ctrl #(.RAW(5), .TW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W; tnew kept as issued at E entry,
    // cycles remaining = issued latency minus stages travelled since E.
    typedef struct {
        int we;
        int dst;
        int rs;
        int rt;
        int tnew;
    } ins_t;

    ins_t pipe [3];
    bit   model_ok = 1'b0;

    function automatic int remaining(input int s);
        int r;
        r = pipe[s].tnew - s;
        return (r < 0) ? 0 : r;
    endfunction

    // Youngest in-flight writer of register r, searching from stage 'first'
    function automatic int producer(input int r, input int first);
        for (int s = first; s < 3; s++)
            if (r != 0 && pipe[s].we != 0 && pipe[s].dst == r) return s;
        return -1;
    endfunction

    function automatic int exp_stall();
        int r [2];
        int tu [2];
        int s;
        r[0]  = int'(hz.d_rs);
        r[1]  = int'(hz.d_rt);
        tu[0] = int'(hz.d_tuse_rs);
        tu[1] = int'(hz.d_tuse_rt);
        for (int i = 0; i < 2; i++) begin
            if (tu[i] != 3) begin
                s = producer(r[i], 0);
                if (s >= 0 && s <= 1 && remaining(s) > tu[i]) return 1;
            end
        end
        return 0;
    endfunction

    function automatic int exp_fwd_d(input int r);
        int s;
        s = producer(r, 0);
        if (s < 0 || remaining(s) != 0) return 0;
        return s + 1;
    endfunction

    function automatic int exp_fwd_e(input int r);
        int s;
        s = producer(r, 1);
        if (s < 0 || remaining(s) != 0) return 0;
        return s;
    endfunction

    function automatic int exp_fwd_m();
        return (producer(pipe[1].rt, 2) == 2) ? 1 : 0;
    endfunction

    // Model advance on every rising edge
    always @(posedge clk) begin : model_step
        int st;
        if (reset) begin
            for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 0};
            model_ok = 1'b1;
        end else if (model_ok) begin
            st = exp_stall();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st != 0) begin
                pipe[0] = '{0, 0, 0, 0, 0};
            end else begin
                pipe[0].we   = int'(hz.d_we);
                pipe[0].dst  = int'(hz.d_dst);
                pipe[0].rs   = int'(hz.d_rs);
                pipe[0].rt   = int'(hz.d_rt);
                pipe[0].tnew = int'(hz.d_tnew);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok) begin
            check("stall",    int'(hz.stall),    exp_stall());
            check("flush_E",  int'(hz.flush_E),  exp_stall());
            check("fwd_rs_D", int'(hz.fwd_rs_D), exp_fwd_d(int'(hz.d_rs)));
            check("fwd_rt_D", int'(hz.fwd_rt_D), exp_fwd_d(int'(hz.d_rt)));
            check("fwd_rs_E", int'(hz.fwd_rs_E), exp_fwd_e(pipe[0].rs));
            check("fwd_rt_E", int'(hz.fwd_rt_E), exp_fwd_e(pipe[0].rt));
            check("fwd_rt_M", int'(hz.fwd_rt_M), exp_fwd_m());
        end
    end

    task automatic set_d(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                         input int dst, input int tnew, input int we);
        hz.d_rs      = 5'(rs);
        hz.d_rt      = 5'(rt);
        hz.d_tuse_rs = 2'(tuse_rs);
        hz.d_tuse_rt = 2'(tuse_rt);
        hz.d_dst     = 5'(dst);
        hz.d_tnew    = 2'(tnew);
        hz.d_we      = 1'(we);
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_stall"},    int'(hz.stall),    0);
        check({tag, "_fwd_rs_D"}, int'(hz.fwd_rs_D), 0);
        check({tag, "_fwd_rt_D"}, int'(hz.fwd_rt_D), 0);
        check({tag, "_fwd_rs_E"}, int'(hz.fwd_rs_E), 0);
        check({tag, "_fwd_rt_E"}, int'(hz.fwd_rt_E), 0);
        check({tag, "_fwd_rt_M"}, int'(hz.fwd_rt_M), 0);
    endtask

    initial begin
        reset = 1'b1;
        nop();
        cyc();
        // 1: under reset, addu $1,$1,$1 in D
        set_d(1, 1, 1, 1, 1, 1, 1);
        #1;
        all_zero("t1");
        cyc();
        reset = 1'b0;
        nop();
        cyc(); cyc();

        // 2: lw $1 then addu rs=$1 (tuse 1)
        set_d(5, 0, 1, 3, 1, 2, 1);
        cyc();
        set_d(1, 2, 1, 1, 6, 1, 1);
        #1;
        check("t2_stall", int'(hz.stall), 1);
        check("t2_flush", int'(hz.flush_E), 1);
        cyc();
        #1;
        check("t2_release", int'(hz.stall), 0);
        check("t2_fwd_rs_D", int'(hz.fwd_rs_D), 0);
        cyc();
        nop();
        #1;
        check("t2_fwd_rs_E", int'(hz.fwd_rs_E), 2);
        cyc(); cyc(); cyc();

        // 3: addu $2 then beq rs=$2 (tuse 0)
        set_d(7, 7, 1, 1, 2, 1, 1);
        cyc();
        set_d(2, 0, 0, 0, 0, 0, 0);
        #1;
        check("t3_stall", int'(hz.stall), 1);
        cyc();
        #1;
        check("t3_release", int'(hz.stall), 0);
        check("t3_fwd_rs_D", int'(hz.fwd_rs_D), 2);
        nop();
        cyc(); cyc(); cyc();

        // 4: jal then jr $31
        set_d(0, 0, 3, 3, 31, 0, 1);
        cyc();
        set_d(31, 0, 0, 3, 0, 0, 0);
        #1;
        check("t4_stall", int'(hz.stall), 0);
        check("t4_fwd_rs_D", int'(hz.fwd_rs_D), 1);
        nop();
        cyc(); cyc(); cyc();

        // 5a: ori $0 then addu rs=$0
        set_d(8, 0, 1, 3, 0, 1, 1);
        cyc();
        set_d(0, 0, 1, 1, 9, 1, 1);
        #1;
        check("t5_stall", int'(hz.stall), 0);
        check("t5_fwd_rs_D", int'(hz.fwd_rs_D), 0);
        check("t5_fwd_rt_D", int'(hz.fwd_rt_D), 0);
        nop();
        cyc(); cyc(); cyc();
        // 5b: two writers of $4, consumer picks the younger (M)
        set_d(9, 9, 1, 1, 4, 1, 1);
        cyc();
        set_d(10, 10, 1, 1, 4, 1, 1);
        cyc();
        set_d(4, 11, 1, 1, 12, 1, 1);
        #1;
        check("t5b_stall", int'(hz.stall), 0);
        cyc();
        nop();
        #1;
        check("t5b_fwd_rs_E", int'(hz.fwd_rs_E), 1);
        cyc(); cyc(); cyc();

        // 6: lw $3 then sw rt=$3 (tuse 2)
        set_d(8, 0, 1, 3, 3, 2, 1);
        cyc();
        set_d(8, 3, 1, 2, 0, 0, 0);
        #1;
        check("t6_stall_d", int'(hz.stall), 0);
        cyc();
        nop();
        #1;
        check("t6_stall_e", int'(hz.stall), 0);
        cyc();
        #1;
        check("t6_fwd_rt_M", int'(hz.fwd_rt_M), 1);
        cyc(); cyc(); cyc();

        // 6b: reset during a load-use stall
        set_d(8, 0, 1, 3, 1, 2, 1);
        cyc();
        set_d(1, 0, 1, 3, 6, 1, 1);
        #1;
        check("t6r_pre_stall", int'(hz.stall), 1);
        reset = 1'b1;
        cyc();
        #1;
        all_zero("t6r");
        reset = 1'b0;
        nop();
        cyc();

        // Randomized decode stream over a small register set
        for (int n = 0; n < 3000; n++) begin
            set_d($urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 2),
                  $urandom_range(0, 1));
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0;
        nop();
        cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
